// File: rtl/ff_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ff_pkg
//  Purpose  : Shared definitions for the flip-flop emulation bank: mode
//             encodings, default bank width, toggle-counter width and
//             saturation value, and the per-bit excitation function that
//             maps a JK/SR/D/T request onto a T flip-flop toggle input.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package ff_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam int DEFAULT_WIDTH = 4;

    localparam int                   TOG_CNT_W   = 8;
    localparam logic [TOG_CNT_W-1:0] TOG_CNT_MAX = '1;

    // Toggle input needed so a T flip-flop holding 'q' lands where the
    // emulated flip-flop type would go. An illegal SR pair (S=R=1) is
    // neutralised to a hold; flagging it is the caller's job.
    function automatic logic excite(input logic [1:0] mode,
                                    input logic       j,
                                    input logic       k,
                                    input logic       q);
        logic w_t;
        w_t = 1'b0;
        case (mode)
            MODE_JK: w_t = (j & ~q) | (k & q);
            MODE_SR: w_t = (j & k) ? 1'b0 : ((j & ~q) | (k & q));
            MODE_D:  w_t = j ^ q;
            default: w_t = j;
        endcase
        return w_t;
    endfunction

endpackage : ff_pkg
`default_nettype wire

// File: rtl/tff_to_jkff_bank_tff.sv
`default_nettype none
// ============================================================================
//  Module   : Tff
//  Purpose  : One-bit T flip-flop with synchronous active-high reset.
//  Ports    : q   - stored state
//             qb  - complement of q
//             t   - toggle request, sampled on rising clk
//             clk - clock
//             rst - synchronous reset, clears q
//  Revision : 1.0  initial release
// ============================================================================
module Tff (
    output logic q,
    output logic qb,
    input  logic t,
    input  logic clk,
    input  logic rst
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;

endmodule : Tff
`default_nettype wire

// File: rtl/tff_to_jkff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tff_to_jkff_bank
//  Purpose  : WIDTH-bit bank of T flip-flops that emulates JK, SR, D or T
//             flip-flops, selected by 'mode'. Each bit's toggle input is
//             derived combinationally from mode, j, k and the current q.
//  Ports    : clk     - clock, all state updates on rising edge
//             rst     - synchronous active-high reset
//             en      - update enable, low holds all state
//             mode    - 00 JK, 01 SR, 10 D, 11 T
//             j       - J / S / D / T per bit
//             k       - K / R per bit (ignored in D and T modes)
//             q       - flip-flop state
//             qb      - complement of q
//             sr_err  - sticky flag for S=R=1 in SR mode, cleared by rst
//             tog_cnt - saturating count of edges with any toggle
//                       (present only with TFF_TO_JKFF_TOG_CNT_EN defined)
//  Config   : TFF_TO_JKFF_TOG_CNT_EN enables the tog_cnt port and counter.
//  Revision : 1.0  initial release
// ============================================================================
module tff_to_jkff_bank
    import ff_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     j,
    input  logic [WIDTH-1:0]     k,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qb,
    output logic                 sr_err
`ifdef TFF_TO_JKFF_TOG_CNT_EN
    ,
    output logic [TOG_CNT_W-1:0] tog_cnt
`endif
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_t_gated;
    logic             w_sr_illegal;
    logic             r_sr_err;

    // Excitation is computed from the live q, so a mode change applies on
    // the very edge at which it is sampled.
    always_comb begin
        w_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_t[i] = excite(mode, j[i], k[i], w_q[i]);
        end
    end

    // Gating the toggle is the whole enable mechanism; each Tff has no
    // enable of its own, and its reset still wins over everything.
    assign w_t_gated    = en ? w_t : '0;
    assign w_sr_illegal = (mode == MODE_SR) && ((j & k) != '0);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bits
        Tff u_tff (
            .q   (w_q[gi]),
            .qb  (w_qb[gi]),
            .t   (w_t_gated[gi]),
            .clk (clk),
            .rst (rst)
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr_err <= 1'b0;
        end else if (en && w_sr_illegal) begin
            r_sr_err <= 1'b1;
        end
    end

    assign q      = w_q;
    assign qb     = w_qb;
    assign sr_err = r_sr_err;

`ifdef TFF_TO_JKFF_TOG_CNT_EN
    logic [TOG_CNT_W-1:0] r_tog_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog_cnt <= '0;
        end else if (en && (w_t != '0) && (r_tog_cnt != TOG_CNT_MAX)) begin
            r_tog_cnt <= r_tog_cnt + 1'b1;
        end
    end

    assign tog_cnt = r_tog_cnt;
`endif

endmodule : tff_to_jkff_bank
`default_nettype wire
